lod_norm_pipe: RTL
==================

Name: lod_norm_pipe

Overview:
- Parametrised, multi-lane, pipelined successor to the combinational leading-one detector/encoder used for SC shift-amount generation.
- Per lane, finds the position of the leading one (MSB-first) or trailing one (LSB-first), encodes it, and emits the data normalised by that position.
- Sits between SC datapath producers and the shifting stage of the CGRA PE.
- Valid/ready streaming on both sides; 2-cycle latency; full throughput.

Parameters:
- DATA_WIDTH, 8, bits per lane (power of 2, >=4).
- LANES, 4, independent lanes processed in lockstep.
- LOG_W, `C_LOG_2(DATA_WIDTH), encoded position width (derived, not overridden).
- FLOOR_POS, 3, minimum reported position; used only when clamp feature is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_mode  in  1  0 = leading-one, 1 = trailing-one; applies to all lanes of the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_pos  out  LANES*LOG_W  encoded position per lane.
- out_norm  out  LANES*DATA_WIDTH  normalised data per lane.
- out_zero  out  LANES  lane input was all zeros.
- out_mode  out  1  mode of the beat on the output.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: all stage valids cleared; out_valid=0, out_pos=0, out_norm=0, out_zero=0, out_mode=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: in-flight beats are discarded and not emitted.
- Pipeline:
  - S1 registers in_data and in_mode on in_valid&&in_ready.
  - S2 registers the per-lane result computed from S1.
  - Latency: accept at cycle N gives out_valid at N+2 when there is no backpressure.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free, combinational from out_ready.
  - S1 advances into S2 when s1_valid && s2_free.
  - A beat transfers out on out_valid && out_ready.
  - out_* are held stable while out_valid && !out_ready.
  - Simultaneous accept and emit in one cycle is supported, giving 1 beat/cycle sustained.
- Per-lane function, with d = lane data and p = position:
  - Leading mode: p = index of the highest set bit; norm = d << (DATA_WIDTH-1-p), so the leading one lands at the MSB.
  - Trailing mode: p = index of the lowest set bit; norm = d >> p, so the trailing one lands at bit 0.
  - Shifts are logical, zero-fill, and truncated to DATA_WIDTH.
  - d==0: zero=1, p=0, norm=0.
- Lanes are fully independent except for the shared mode and handshake.
- Detection is priority-based, so any input pattern is legal, not only one-hot.
- No internal state beyond the 2 stage registers and their valids.
- No FSM beyond the valid/stall control.

Optional Feature:
- Macro: LOD_NORM_FLOOR_CLAMP_EN.
- Defined:
  - In leading mode, the reported position is max(p, FLOOR_POS), and norm uses the clamped position, i.e. d << (DATA_WIDTH-1-max(p,FLOOR_POS)).
  - Zero input reports p=FLOOR_POS with zero=1 and norm=0.
  - Trailing mode is unaffected.
  - This matches the legacy encoder default-floor behaviour.
- Undefined: exact positions as described in Behaviour; FLOOR_POS is ignored.

Test Plan:
- Leading mode, lanes {0x2C,0x80,0x01,0xFF}, out_ready=1 → 2 cycles later: pos {5,7,0,7}, norm {0xB0,0x80,0x80,0xFF}, zero=0000.
- Trailing mode, lanes {0x2C,0x80,0x01,0x00} → pos {2,7,0,0}, norm {0x0B,0x01,0x01,0x00}, zero=1000 (lane 3).
- Back-to-back 16 beats with random out_ready (≈50% duty) → no beat lost or duplicated, order preserved, out_* stable during stalls. With out_ready=1 the 16 beats emit in 16 consecutive cycles.
- out_ready=0 with 3 beats offered → exactly 2 accepted, in_ready=0 thereafter; raise out_ready → both emitted in order, and the third is accepted the same cycle the first leaves.
- rst asserted for 1 cycle with 2 beats in flight → out_valid=0 the next cycle, outputs zero, those beats never appear, in_ready=1.
- With LOD_NORM_FLOOR_CLAMP_EN, FLOOR_POS=3, leading mode, lane 0x05 → pos 3, norm 0x50. Lane 0x00 → pos 3, zero=1. Without the macro, 0x05 → pos 2, norm 0xA0.

Source files
------------

// File: rtl/lod_norm_pipe.sv
// -----------------------------------------------------------------------------
// lod_norm_pipe
//
// Multi-lane, two-stage pipelined leading/trailing-one detector and normaliser.
// Each lane finds the leading one (MSB-first) or the trailing one (LSB-first)
// of its data word, reports the bit index, and emits the word shifted so that
// this one lands at the MSB (leading mode) or at bit 0 (trailing mode).
// Feeds shift amounts and pre-normalised operands to the PE shifting stage.
//
// Parameters
//   DATA_WIDTH  bits per lane (power of two, >= 4)
//   LANES       lanes processed in lockstep
//   FLOOR_POS   minimum reported position in leading mode; only used when
//               LOD_NORM_FLOOR_CLAMP_EN is defined
//   LOG_W       (localparam) encoded position width = $clog2(DATA_WIDTH)
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   block accepts a beat this cycle (combinational from out_ready)
//   in_data    lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_mode    0 = leading-one, 1 = trailing-one (whole beat)
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_pos    encoded position, lane i at [i*LOG_W +: LOG_W]
//   out_norm   normalised data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_zero   lane i input was all zeros
//   out_mode   mode of the beat on the output
//
// Compile-time option
//   LOD_NORM_FLOOR_CLAMP_EN  when defined, leading-mode positions are clamped
//                            to at least FLOOR_POS (legacy encoder floor), and
//                            the normalising shift uses the clamped position.
//                            Trailing mode is never clamped.
// -----------------------------------------------------------------------------
module lod_norm_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int FLOOR_POS  = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]            in_data,
    input  logic                                   in_mode,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [LANES*$clog2(DATA_WIDTH)-1:0]    out_pos,
    output logic [LANES*DATA_WIDTH-1:0]            out_norm,
    output logic [LANES-1:0]                       out_zero,
    output logic                                   out_mode
);

    localparam int LOG_W = $clog2(DATA_WIDTH);

    // Index of the MSB, used as the base of the leading-mode shift amount.
    localparam logic [LOG_W-1:0] MAX_P = LOG_W'(DATA_WIDTH - 1);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks.
    // -------------------------------------------------------------------------
    if (DATA_WIDTH < 4 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
        $error("lod_norm_pipe: DATA_WIDTH must be a power of two >= 4");
    end

    if (FLOOR_POS < 0 || FLOOR_POS >= DATA_WIDTH) begin : g_bad_floor
        $error("lod_norm_pipe: FLOOR_POS must lie in [0, DATA_WIDTH-1]");
    end

    // -------------------------------------------------------------------------
    // Handshake (both sides follow strict valid/ready rules):
    //   - A beat moves across an interface on a cycle where valid && ready.
    //   - A producer never withdraws or changes a beat while valid && !ready;
    //     this block holds out_* stable in that situation.
    //   - S2 (the output register) can take a new beat when it is empty or
    //     its current beat leaves this cycle (s2_free).
    //   - S1 can take a new beat when it is empty or it moves into S2 this
    //     cycle, so in_ready depends combinationally on out_ready. This is
    //     what lets accept and emit happen in the same cycle (1 beat/cycle).
    // -------------------------------------------------------------------------
    logic                          s1_valid;
    logic [LANES*DATA_WIDTH-1:0]   s1_data;
    logic                          s1_mode;
    logic                          s2_free;
    logic                          s1_load;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign s1_load  = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Per-lane detect / encode / normalise, computed from the S1 register.
    // -------------------------------------------------------------------------
    logic [LANES*LOG_W-1:0]        calc_pos;
    logic [LANES*DATA_WIDTH-1:0]   calc_norm;
    logic [LANES-1:0]              calc_zero;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] d;
        logic [LOG_W-1:0]      lead_p;
        logic [LOG_W-1:0]      trail_p;
        logic [LOG_W-1:0]      p;
        logic [DATA_WIDTH-1:0] norm;

        assign d = s1_data[g*DATA_WIDTH +: DATA_WIDTH];

        // Priority scan upward: the last set bit seen is the highest one.
        // Any bit pattern is legal; all-zero leaves the default 0.
        always_comb begin
            lead_p = '0;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (d[i]) begin
                    lead_p = LOG_W'(i);
                end
            end
        end

        // Priority scan downward: the last set bit seen is the lowest one.
        always_comb begin
            trail_p = '0;
            for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
                if (d[i]) begin
                    trail_p = LOG_W'(i);
                end
            end
        end

        // Select the position for the beat's mode and normalise with it.
        // A zero lane naturally yields norm = 0 for either shift direction.
        always_comb begin
            p    = s1_mode ? trail_p : lead_p;
`ifdef LOD_NORM_FLOOR_CLAMP_EN
            // Legacy floor: leading positions below FLOOR_POS (including the
            // all-zero case) are reported as FLOOR_POS, and the shift follows
            // the clamped value so norm and pos stay consistent.
            if (!s1_mode && (lead_p < LOG_W'(FLOOR_POS))) begin
                p = LOG_W'(FLOOR_POS);
            end
`endif
            norm = '0;
            if (s1_mode) begin
                norm = d >> p;
            end else begin
                norm = d << (MAX_P - p);
            end
        end

        assign calc_pos[g*LOG_W +: LOG_W]           = p;
        assign calc_norm[g*DATA_WIDTH +: DATA_WIDTH] = norm;
        assign calc_zero[g]                          = ~|d;
    end

    // -------------------------------------------------------------------------
    // Stage 1: input register.
    // Loads on acceptance; empties when its beat moves to S2 and nothing new
    // arrives behind it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
                s1_mode  <= in_mode;
            end else if (s2_free) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: result register, which directly drives the outputs.
    // Only written when free, so a stalled beat is held unchanged. Payload is
    // only overwritten by a real beat; when the pipe drains, the old payload
    // remains visible with out_valid low.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_norm  <= '0;
            out_zero  <= '0;
            out_mode  <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_pos  <= calc_pos;
                out_norm <= calc_norm;
                out_zero <= calc_zero;
                out_mode <= s1_mode;
            end
        end
    end

endmodule
